psram_qspi_model: RTL
=====================

# psram_qspi_model

Parametrised QSPI/QPI PSRAM device model for the SoC's PSRAM controller. It is the next generation of the fixed-width PSRAM slave and adds:
- an internal byte-addressable array, in place of external read/write hooks;
- open-ended read and write bursts with page wrap;
- a configurable read latency;
- reset-enable/reset and QPI enter/exit command handling.

It sits on the controller's `sck`/`ce_n`/`dio` pins in the simulation top, with tri-state resolved outside the block.

## Interface
- `MEM_BYTES`, default 4194304: array size; must be a power of two; upper address bits alias.
- `ADDR_W`, default 24: address bits shifted in per command.
- `READ_WAIT`, default 6: dummy cycles between the address phase and read data; range 1–15.
- `PAGE_BYTES`, default 1024: burst wrap boundary; must be a power of two and ≤ `MEM_BYTES`.

Ports (clock and reset first):
- `sck` in 1: serial clock; all sampling and launching happens on its rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `ce_n` in 1: chip enable, active-low. Its rising edge asynchronously aborts or ends the transaction.
- `dio_i` in 4: pad input. Bit 0 carries single-bit command data.
- `dio_o` out 4: pad output data.
- `dio_oe` out 4: per-bit output enable, all-or-nothing.

## Operation
- **Command opcodes**
  - 0xEB: quad read.
  - 0x38: quad write.
  - 0x35: enter QPI.
  - 0xF5: exit QPI.
  - 0x66: reset enable.
  - 0x99: reset.
  - Any other opcode sends the FSM to `SKIP`, which ignores input until `ce_n` rises.
- **Command phase width**
  - SPI mode: command is 8 cycles, 1 bit per cycle on `dio_i[0]`, MSB first.
  - QPI mode: command is 2 cycles, 4 bits per cycle, high nibble first.
  - Address and data are always 4 bits per cycle, MSB/high nibble first.
- **Address phase**: `ADDR_W/4` cycles. The address is truncated to `log2(MEM_BYTES)` bits.
- **FSM states**: `IDLE`, `CMD`, `ADDR`, `WAIT`, `RDATA`, `WDATA`, `SKIP`.
  - `IDLE` → `CMD` on the first `sck` edge with `ce_n`=0.
  - `CMD` → `ADDR` for 0xEB/0x38. → `SKIP` for all other opcodes, after their action is performed.
  - `ADDR` → `WAIT` for a read. → `WDATA` for a write.
  - `WAIT` → `RDATA` after `READ_WAIT` cycles.
  - `RDATA` and `WDATA` persist until `ce_n` rises.
  - `ce_n`=1 forces `IDLE` asynchronously and clears the counters, shift registers and `dio_oe`.
- **Read burst**
  - Each byte is output high nibble then low nibble.
  - After each byte the address increments within the page: low `log2(PAGE_BYTES)` bits wrap, upper bits are held.
  - Unbounded length.
- **Write burst**
  - Every completed nibble pair writes one byte to `mem[addr]`, then the address increments with the same page wrap.
  - A trailing odd nibble at the `ce_n` rise is discarded.
- **QPI mode flag**
  - Set by 0x35 and cleared by 0xF5, at the end of the command phase.
  - Cleared by `reset`.
  - Cleared by the reset sequence: 0x66 then 0x99 in consecutive transactions. Any other command in between disarms the reset-enable.
- **Reset behaviour**
  - Reset values: `dio_o`=0, `dio_oe`=0, state `IDLE`, QPI flag 0, reset-enable disarmed.
  - Array contents are not reset.
  - `reset` mid-burst abandons the burst; bytes already written persist.

## Timing
- **SPI read, 0xEB**
  - Cycles 0–7: command.
  - Cycles 8–13: address (`ADDR_W`=24).
  - Cycles 14 to 13+`READ_WAIT`: wait.
  - `dio_oe`=4'hF and the first nibble are launched on the `sck` edge that closes the last wait cycle, and are valid throughout cycle 14+`READ_WAIT`.
  - Total for 4 bytes at defaults: 8+6+6+8 = 28 cycles.
- **QPI read**: identical, with the command phase at 2 cycles.
- **Write**
  - Data nibbles are sampled from cycle 14 (SPI) or cycle 8 (QPI).
  - The byte write occurs at the sampling edge of the low nibble.
- **Output enable**: `dio_oe` is 0 in every state except `RDATA`.
- **Simultaneous events**: `ce_n` rising on the same edge as `sck` — `ce_n` wins and no sample is taken.

## Configuration
- `PSRAM_QPI_EN` defined: 0x35/0xF5 are honoured and QPI 2-cycle commands are supported.
- `PSRAM_QPI_EN` undefined:
  - 0x35/0xF5 are treated as unknown opcodes (→ `SKIP`).
  - The QPI flag is tied to 0.
  - The command phase is always 8 single-bit cycles.

## Structure
- **Shared package `psram_pkg`**:
  - state enum `psram_state_t`;
  - opcode constants `PSRAM_CMD_QREAD`, `PSRAM_CMD_QWRITE`, `PSRAM_CMD_QPI_EN`, `PSRAM_CMD_QPI_EX`, `PSRAM_CMD_RST_EN`, `PSRAM_CMD_RST`.
- **Sub-module `psram_mem`**:
  - byte array parametrised by `MEM_BYTES`;
  - one combinational read port;
  - one synchronous write port on `sck`.
- **Top level**: the FSM, counters, address/page-wrap logic and output shifter stay in `psram_qspi_model`.

## Test plan
- **SPI write/read**: SPI write 0x38, addr 0x000100, data bytes 0xDE 0xAD 0xBE 0xEF; then SPI 0xEB at 0x000100 → nibbles D,E,A,D,B,E,E,F. The first nibble appears at cycle 20; read completes in 28 cycles.
- **Page wrap**: write 0x11,0x22 at 0x0003FF → mem[0x3FF]=0x11 and mem[0x000]=0x22 (wrap). mem[0x400] is unchanged.
- **QPI round trip**: 0x35 in SPI, then a 2-cycle QPI 0xEB at 0x000100 → the first nibble appears at cycle 14. Then 0x66, 0x99 → the next command is decoded as 8-cycle SPI.
- **Odd-nibble abort**: `ce_n` raised after 3 data nibbles of a write at 0x20 with data 0xA5,0x3_ → mem[0x20]=0xA5 and mem[0x21] is unchanged. The next transaction decodes normally.
- **Async reset mid-read**: `reset` pulsed mid-read → `dio_oe`=0 immediately, QPI flag 0, array intact on re-read.
- **Macro off**: without `PSRAM_QPI_EN`, command 0x35 → `SKIP`. The following command is still decoded as 8-cycle SPI.

Source files
------------

// File: rtl/psram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | psram_pkg                                                                  |
// | Shared FSM state type and command opcodes for the QSPI/QPI PSRAM model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package psram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RDATA = 3'd4,
        ST_WDATA = 3'd5,
        ST_SKIP  = 3'd6
    } psram_state_t;

    localparam logic [7:0] PSRAM_CMD_QREAD  = 8'hEB;
    localparam logic [7:0] PSRAM_CMD_QWRITE = 8'h38;
    localparam logic [7:0] PSRAM_CMD_QPI_EN = 8'h35;
    localparam logic [7:0] PSRAM_CMD_QPI_EX = 8'hF5;
    localparam logic [7:0] PSRAM_CMD_RST_EN = 8'h66;
    localparam logic [7:0] PSRAM_CMD_RST    = 8'h99;

endpackage
`default_nettype wire

// File: rtl/psram_qspi_model_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | psram_qspi_model_if                                                        |
// | Pad-level bus between the PSRAM controller (master) and the model (slave). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface psram_qspi_model_if;
    logic       ce_n;
    logic [3:0] dio_i;
    logic [3:0] dio_o;
    logic [3:0] dio_oe;

    modport master (output ce_n, output dio_i, input dio_o, input dio_oe);
    modport slave  (input ce_n, input dio_i, output dio_o, output dio_oe);
endinterface
`default_nettype wire

// File: rtl/psram_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | psram_mem                                                                  |
// | Byte array: combinational read port, write port clocked on sck.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module psram_mem #(
    parameter int MEM_BYTES = 4194304,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          sck,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [MEM_BYTES];

    always_ff @(posedge sck) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule
`default_nettype wire

// File: rtl/psram_qspi_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | psram_qspi_model                                                           |
// | QSPI/QPI PSRAM device model with page-wrapping bursts and read latency.    |
// | Optional feature macro: PSRAM_QPI_EN (QPI enter/exit and 2-cycle commands) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module psram_qspi_model
    import psram_pkg::*;
#(
    parameter int MEM_BYTES  = 4194304,
    parameter int ADDR_W     = 24,
    parameter int READ_WAIT  = 6,
    parameter int PAGE_BYTES = 1024
) (
    input  logic               sck,
    input  logic               reset,
    psram_qspi_model_if.slave  bus
);
    localparam int              AW        = $clog2(MEM_BYTES);
    localparam int              CNT_W     = 5;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W / 4 - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT - 1);
    localparam logic [AW-1:0]   PAGE_MASK = AW'(PAGE_BYTES - 1);

    psram_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             nib_q, nib_d;
    logic [3:0]       hi_q, hi_d;
    logic [3:0]       dout_q, dout_d;
    logic             oe_q, oe_d;
    logic             qpi_q, qpi_d;
    logic             rsten_q, rsten_d;

    logic [7:0]       cmd_shift;
    logic             cmd_last;
    logic [AW-1:0]    addr_inc;
    logic             mem_we;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem_rdata;

`ifdef PSRAM_QPI_EN
    assign cmd_shift = qpi_q ? {cmd_q[3:0], bus.dio_i} : {cmd_q[6:0], bus.dio_i[0]};
    assign cmd_last  = qpi_q ? (cnt_q == CNT_W'(1)) : (cnt_q == CNT_W'(7));
`else
    assign cmd_shift = {cmd_q[6:0], bus.dio_i[0]};
    assign cmd_last  = (cnt_q == CNT_W'(7));
`endif

    // Page wrap: only the in-page offset bits advance.
    assign addr_inc = (addr_q & ~PAGE_MASK) | ((addr_q + 1'b1) & PAGE_MASK);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        nib_d     = nib_q;
        hi_d      = hi_q;
        dout_d    = dout_q;
        oe_d      = 1'b0;
        qpi_d     = qpi_q;
        rsten_d   = rsten_q;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        case (state_q)
            ST_IDLE: begin
                cmd_d   = cmd_shift;
                cnt_d   = CNT_W'(1);
                state_d = ST_CMD;
            end
            ST_CMD: begin
                cmd_d = cmd_shift;
                cnt_d = cnt_q + 1'b1;
                if (cmd_last) begin
                    cnt_d   = '0;
                    state_d = ST_SKIP;
                    rsten_d = 1'b0;
                    case (cmd_shift)
                        PSRAM_CMD_QREAD, PSRAM_CMD_QWRITE: state_d = ST_ADDR;
`ifdef PSRAM_QPI_EN
                        PSRAM_CMD_QPI_EN: qpi_d = 1'b1;
                        PSRAM_CMD_QPI_EX: qpi_d = 1'b0;
`endif
                        PSRAM_CMD_RST_EN: rsten_d = 1'b1;
                        PSRAM_CMD_RST:    if (rsten_q) qpi_d = 1'b0;
                        default: ;
                    endcase
                end
            end
            ST_ADDR: begin
                addr_d = {addr_q[AW-5:0], bus.dio_i};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == ADDR_LAST) begin
                    cnt_d   = '0;
                    nib_d   = 1'b0;
                    state_d = (cmd_q == PSRAM_CMD_QREAD) ? ST_WAIT : ST_WDATA;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RDATA;
                    oe_d    = 1'b1;
                    dout_d  = mem_rdata[7:4];
                    nib_d   = 1'b1;
                end
            end
            ST_RDATA: begin
                oe_d = 1'b1;
                if (nib_q) begin
                    dout_d = mem_rdata[3:0];
                    addr_d = addr_inc;
                    nib_d  = 1'b0;
                end else begin
                    dout_d = mem_rdata[7:4];
                    nib_d  = 1'b1;
                end
            end
            ST_WDATA: begin
                if (nib_q) begin
                    mem_we    = ~bus.ce_n;
                    mem_wdata = {hi_q, bus.dio_i};
                    addr_d    = addr_inc;
                    nib_d     = 1'b0;
                end else begin
                    hi_d  = bus.dio_i;
                    nib_d = 1'b1;
                end
            end
            ST_SKIP: ;
            default: state_d = ST_IDLE;
        endcase
    end

    // Deasserted chip enable holds the transaction logic in its idle state.
    always_ff @(posedge sck or posedge reset or posedge bus.ce_n) begin
        if (reset || bus.ce_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            nib_q   <= 1'b0;
            hi_q    <= '0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            nib_q   <= nib_d;
            hi_q    <= hi_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
        end
    end

    always_ff @(posedge sck or posedge reset) begin
        if (reset) begin
            qpi_q   <= 1'b0;
            rsten_q <= 1'b0;
        end else if (!bus.ce_n) begin
            qpi_q   <= qpi_d;
            rsten_q <= rsten_d;
        end
    end

    psram_mem #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_mem (
        .sck     (sck),
        .we_i    (mem_we),
        .waddr_i (addr_q),
        .wdata_i (mem_wdata),
        .raddr_i (addr_q),
        .rdata_o (mem_rdata)
    );

    assign bus.dio_o  = dout_q;
    assign bus.dio_oe = {4{oe_q}};
endmodule
`default_nettype wire
